// File: rtl/pixel_dispatcher_if.sv
// pixel_dispatcher_if: depth-calculator job bus plus pixel result stream.
// master = dispatcher side, slave = calculator/consumer side.
interface pixel_dispatcher_if #(
  parameter int WORD_LENGTH = 32
);
  logic                          calc_start;
  logic [9:0]                    calc_x;
  logic [8:0]                    calc_y;
  logic signed [WORD_LENGTH-1:0] calc_re_c;
  logic signed [WORD_LENGTH-1:0] calc_im_c;
  logic [9:0]                    calc_max_iter;
  logic                          calc_done;
  logic [9:0]                    calc_depth;
  logic                          out_valid;
  logic                          out_ready;
  logic [9:0]                    out_depth;
  logic [9:0]                    out_x;
  logic [8:0]                    out_y;
  logic                          out_sof;
  logic                          out_eol;

  modport master (
    output calc_start, calc_x, calc_y,
    output calc_re_c, calc_im_c, calc_max_iter,
    input  calc_done, calc_depth,
    output out_valid, out_depth, out_x, out_y,
    output out_sof, out_eol,
    input  out_ready
  );

  modport slave (
    input  calc_start, calc_x, calc_y,
    input  calc_re_c, calc_im_c, calc_max_iter,
    output calc_done, calc_depth,
    input  out_valid, out_depth, out_x, out_y,
    input  out_sof, out_eol,
    output out_ready
  );
endinterface

// File: rtl/pixel_dispatcher.sv
// pixel_dispatcher: walks a frame in raster order, issues one depth job per
// pixel, streams results. Option: PIXEL_DISPATCHER_CYCLE_COUNT_EN adds frame_cycles.
module pixel_dispatcher #(
  parameter int WORD_LENGTH = 32,
  parameter int H_RES       = 640,
  parameter int V_RES       = 480
) (
  input  logic                          sysclk,
  input  logic                          reset_n,
  input  logic signed [WORD_LENGTH-1:0] re_origin,
  input  logic signed [WORD_LENGTH-1:0] im_origin,
  input  logic signed [WORD_LENGTH-1:0] step,
  input  logic [9:0]                    max_iter_in,
  input  logic                          frame_start,
  output logic                          frame_busy,
  pixel_dispatcher_if.master            bus
`ifdef PIXEL_DISPATCHER_CYCLE_COUNT_EN
  ,
  output logic [31:0]                   frame_cycles
`endif
);

  localparam logic [9:0] X_LAST = 10'(H_RES - 1);
  localparam logic [8:0] Y_LAST = 9'(V_RES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_FLUSH
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [WORD_LENGTH-1:0] r_re_org;
  logic signed [WORD_LENGTH-1:0] r_step;
  logic signed [WORD_LENGTH-1:0] r_re_c;
  logic signed [WORD_LENGTH-1:0] r_im_c;
  logic [9:0]                    r_max_iter;
  logic [9:0]                    r_x;
  logic [8:0]                    r_y;

  logic       r_valid;
  logic [9:0] r_depth;
  logic [9:0] r_ox;
  logic [8:0] r_oy;

  logic w_accept;
  logic w_capture;
  logic w_xfer;
  logic w_last;

  assign w_accept  = (r_state == S_IDLE) && frame_start;
  assign w_xfer    = r_valid && bus.out_ready;
  assign w_capture = (r_state == S_WAIT) && bus.calc_done &&
                     (!r_valid || bus.out_ready);
  assign w_last    = (r_x == X_LAST) && (r_y == Y_LAST);

  // state register
  always_ff @(posedge sysclk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // next-state: one launch per pixel, flush the last result before idling
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (frame_start) w_next = S_LAUNCH;
      S_LAUNCH: w_next = S_WAIT;
      S_WAIT: begin
        if (w_capture) w_next = w_last ? S_FLUSH : S_LAUNCH;
      end
      S_FLUSH:  if (!r_valid) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // frame parameters and incremental pixel coordinate walk
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      r_re_org   <= '0;
      r_step     <= '0;
      r_max_iter <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_re_c     <= '0;
      r_im_c     <= '0;
    end else if (w_accept) begin
      r_re_org   <= re_origin;
      r_step     <= step;
      r_max_iter <= max_iter_in;
      r_x        <= '0;
      r_y        <= '0;
      r_re_c     <= re_origin;
      r_im_c     <= im_origin;
    end else if (w_capture && !w_last) begin
      if (r_x == X_LAST) begin
        r_x    <= '0;
        r_y    <= r_y + 9'd1;
        r_re_c <= r_re_org;
        r_im_c <= r_im_c - r_step;
      end else begin
        r_x    <= r_x + 10'd1;
        r_re_c <= r_re_c + r_step;
      end
    end
  end

  // one-entry result register; capture may coincide with a transfer
  always_ff @(posedge sysclk) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_depth <= '0;
      r_ox    <= '0;
      r_oy    <= '0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_depth <= bus.calc_depth;
      r_ox    <= r_x;
      r_oy    <= r_y;
    end else if (w_xfer) begin
      r_valid <= 1'b0;
    end
  end

  assign frame_busy        = (r_state != S_IDLE);
  assign bus.calc_start    = (r_state == S_LAUNCH);
  assign bus.calc_x        = r_x;
  assign bus.calc_y        = r_y;
  assign bus.calc_re_c     = r_re_c;
  assign bus.calc_im_c     = r_im_c;
  assign bus.calc_max_iter = r_max_iter;
  assign bus.out_valid     = r_valid;
  assign bus.out_depth     = r_depth;
  assign bus.out_x         = r_ox;
  assign bus.out_y         = r_oy;
  assign bus.out_sof       = r_valid && (r_ox == '0) && (r_oy == '0);
  assign bus.out_eol       = r_valid && (r_ox == X_LAST);

`ifdef PIXEL_DISPATCHER_CYCLE_COUNT_EN
  logic [31:0] r_cycles;

  // busy-cycle counter, restarted by each accepted frame
  always_ff @(posedge sysclk) begin
    if (!reset_n)        r_cycles <= '0;
    else if (w_accept)   r_cycles <= '0;
    else if (frame_busy) r_cycles <= r_cycles + 32'd1;
  end

  assign frame_cycles = r_cycles;
`endif

endmodule

// File: tb/tb_pixel_dispatcher.sv
// tb_pixel_dispatcher: 4x2 frames against a raster-order reference model,
// with a behavioural depth calculator and randomized ready/latency.
module tb_pixel_dispatcher;
  localparam int WL = 32;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int N  = H * V;

  logic        sysclk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] re_origin = '0;
  logic [31:0] im_origin = '0;
  logic [31:0] step = '0;
  logic [9:0]  max_iter_in = '0;
  logic        frame_start = 1'b0;
  logic        frame_busy;
`ifdef PIXEL_DISPATCHER_CYCLE_COUNT_EN
  logic [31:0] frame_cycles;
`endif

  pixel_dispatcher_if #(.WORD_LENGTH(WL)) bus_if ();

  pixel_dispatcher #(
    .WORD_LENGTH(WL),
    .H_RES(H),
    .V_RES(V)
  ) dut (
    .sysclk(sysclk),
    .reset_n(reset_n),
    .re_origin(re_origin),
    .im_origin(im_origin),
    .step(step),
    .max_iter_in(max_iter_in),
    .frame_start(frame_start),
    .frame_busy(frame_busy),
    .bus(bus_if)
`ifdef PIXEL_DISPATCHER_CYCLE_COUNT_EN
    ,
    .frame_cycles(frame_cycles)
`endif
  );

  always #5 sysclk = ~sysclk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: unexpected event @%0t", nm, $time);
  endtask

  // reference model state
  bit          m_active = 0;
  int          m_job = 0, m_pix = 0, m_tail = 0, m_sof = 0, m_busy_cnt = 0;
  logic [31:0] m_re0 = '0, m_im0 = '0, m_step = '0;
  logic [9:0]  m_mi = '0;
  int          m_mode = 0;
  logic [9:0]  m_seed = '0;
  int          tab[4] = '{5, 9, 0, 10};
  logic [9:0]  got_d[$];
  logic [31:0] lit_re = '0, lit_im = '0;

  function automatic logic [9:0] depth_of(input int x, input int y);
    int k;
    k = y * H + x;
    if (m_mode == 0) return 10'(tab[k % 4]);
    return 10'((x * 37 + y * 101) ^ int'(m_seed));
  endfunction

  // depth calculator: done level held until the next start
  int c_lat = 3;
  bit c_rand_lat = 0;
  initial begin
    bit st;
    bit pend;
    int cnt;
    logic [9:0] d;
    pend = 0; cnt = 0; d = '0;
    bus_if.calc_done = 1'b0;
    bus_if.calc_depth = '0;
    forever begin
      @(negedge sysclk);
      st = bus_if.calc_start;
      if (st) d = depth_of(int'(bus_if.calc_x), int'(bus_if.calc_y));
      @(posedge sysclk);
      #1;
      if (st) begin
        bus_if.calc_done = 1'b0;
        pend = 1;
        cnt = c_rand_lat ? int'($urandom_range(0, 4)) : c_lat;
      end
      if (pend) begin
        if (cnt == 0) begin
          bus_if.calc_done = 1'b1;
          bus_if.calc_depth = d;
          pend = 0;
        end else cnt--;
      end
    end
  end

  // output consumer
  int rdy_mode = 0;
  initial begin
    bus_if.out_ready = 1'b1;
    forever begin
      @(posedge sysclk);
      #1;
      case (rdy_mode)
        0:       bus_if.out_ready = 1'b1;
        1:       bus_if.out_ready = 1'($urandom_range(0, 1));
        default: bus_if.out_ready = 1'b0;
      endcase
    end
  end

  // compare process
  bit         p_valid = 0, p_ready = 0, p_start = 0, p_sof = 0, p_eol = 0;
  logic [9:0] p_x = '0, p_d = '0;
  logic [8:0] p_y = '0;

  always @(negedge sysclk) begin
    int x, y;
    if (!reset_n) begin
      p_valid = 0;
      p_start = 0;
    end else begin
      if (m_active) begin
        if (frame_busy) m_busy_cnt++;
        if (m_tail == 1) begin
          chk("busy_flush", 32'(frame_busy), 32'd1);
          m_tail = 2;
        end else if (m_tail == 2) begin
          chk("busy_end", 32'(frame_busy), 32'd0);
`ifdef PIXEL_DISPATCHER_CYCLE_COUNT_EN
          chk("frame_cycles", frame_cycles, 32'(m_busy_cnt));
`endif
          m_active = 0;
          m_tail = 0;
        end else begin
          chk("busy_run", 32'(frame_busy), 32'd1);
        end
      end else begin
        chk("busy_idle", 32'(frame_busy), 32'd0);
        chk("valid_idle", 32'(bus_if.out_valid), 32'd0);
        if (frame_start) begin
          m_active = 1;
          m_re0 = re_origin;
          m_im0 = im_origin;
          m_step = step;
          m_mi = max_iter_in;
          m_job = 0;
          m_pix = 0;
          m_tail = 0;
          m_sof = 0;
          m_busy_cnt = 0;
        end
      end

      if (bus_if.calc_start) begin
        chk("start_pulse", 32'(p_start), 32'd0);
        if (!m_active || m_job >= N) fail("start_extra");
        else begin
          x = m_job % H;
          y = m_job / H;
          chk("calc_x", 32'(bus_if.calc_x), 32'(x));
          chk("calc_y", 32'(bus_if.calc_y), 32'(y));
          chk("calc_re", bus_if.calc_re_c, m_re0 + 32'(x) * m_step);
          chk("calc_im", bus_if.calc_im_c, m_im0 - 32'(y) * m_step);
          chk("calc_mi", 32'(bus_if.calc_max_iter), 32'(m_mi));
          if (x == 3 && y == 1) begin
            lit_re = bus_if.calc_re_c;
            lit_im = bus_if.calc_im_c;
          end
          m_job++;
        end
      end

      if (bus_if.out_valid && bus_if.out_ready) begin
        if (!m_active || m_pix >= N) fail("out_extra");
        else begin
          x = m_pix % H;
          y = m_pix / H;
          chk("out_x", 32'(bus_if.out_x), 32'(x));
          chk("out_y", 32'(bus_if.out_y), 32'(y));
          chk("out_depth", 32'(bus_if.out_depth), 32'(depth_of(x, y)));
          chk("out_sof", 32'(bus_if.out_sof), 32'(x == 0 && y == 0));
          chk("out_eol", 32'(bus_if.out_eol), 32'(x == H - 1));
          if (bus_if.out_sof) m_sof++;
          got_d.push_back(bus_if.out_depth);
          m_pix++;
          if (m_pix == N) m_tail = 1;
        end
      end

      if (!bus_if.out_valid) begin
        chk("sof_qual", 32'(bus_if.out_sof), 32'd0);
        chk("eol_qual", 32'(bus_if.out_eol), 32'd0);
      end

      if (p_valid && !p_ready) begin
        chk("hold_valid", 32'(bus_if.out_valid), 32'd1);
        chk("hold_x", 32'(bus_if.out_x), 32'(p_x));
        chk("hold_y", 32'(bus_if.out_y), 32'(p_y));
        chk("hold_depth", 32'(bus_if.out_depth), 32'(p_d));
        chk("hold_sof", 32'(bus_if.out_sof), 32'(p_sof));
        chk("hold_eol", 32'(bus_if.out_eol), 32'(p_eol));
      end

      p_valid = bus_if.out_valid;
      p_ready = bus_if.out_ready;
      p_start = bus_if.calc_start;
      p_x = bus_if.out_x;
      p_y = bus_if.out_y;
      p_d = bus_if.out_depth;
      p_sof = bus_if.out_sof;
      p_eol = bus_if.out_eol;
    end
  end

  task automatic start_frame(input logic [31:0] re0, input logic [31:0] im0,
                             input logic [31:0] st, input logic [9:0] mi);
    @(posedge sysclk);
    #1;
    re_origin = re0;
    im_origin = im0;
    step = st;
    max_iter_in = mi;
    frame_start = 1'b1;
    @(posedge sysclk);
    #1;
    frame_start = 1'b0;
    re_origin = $urandom;
    im_origin = $urandom;
    step = $urandom;
    max_iter_in = 10'($urandom);
  endtask

  task automatic pulse_reset();
    @(posedge sysclk);
    #1;
    reset_n = 1'b0;
    m_active = 0;
    m_tail = 0;
    @(posedge sysclk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic wait_done(input string nm);
    int n;
    n = 0;
    while (m_active && n < 3000) begin
      @(negedge sysclk);
      n++;
    end
    if (m_active) begin
      fail(nm);
      pulse_reset();
    end
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_busy"}, 32'(frame_busy), 32'd0);
    chk({pfx, "_start"}, 32'(bus_if.calc_start), 32'd0);
    chk({pfx, "_cx"}, 32'(bus_if.calc_x), 32'd0);
    chk({pfx, "_cy"}, 32'(bus_if.calc_y), 32'd0);
    chk({pfx, "_cre"}, bus_if.calc_re_c, 32'd0);
    chk({pfx, "_cim"}, bus_if.calc_im_c, 32'd0);
    chk({pfx, "_cmi"}, 32'(bus_if.calc_max_iter), 32'd0);
    chk({pfx, "_valid"}, 32'(bus_if.out_valid), 32'd0);
    chk({pfx, "_depth"}, 32'(bus_if.out_depth), 32'd0);
    chk({pfx, "_ox"}, 32'(bus_if.out_x), 32'd0);
    chk({pfx, "_oy"}, 32'(bus_if.out_y), 32'd0);
    chk({pfx, "_sof"}, 32'(bus_if.out_sof), 32'd0);
    chk({pfx, "_eol"}, 32'(bus_if.out_eol), 32'd0);
`ifdef PIXEL_DISPATCHER_CYCLE_COUNT_EN
    chk({pfx, "_cycles"}, frame_cycles, 32'd0);
`endif
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n = 1'b0;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    chk_all_zero("reset");
    @(posedge sysclk);
    #1;
    reset_n = 1'b1;

    // literal frame: fixed latency, table depths, always ready
    m_mode = 0;
    c_rand_lat = 0;
    c_lat = 3;
    rdy_mode = 0;
    got_d.delete();
    start_frame(32'hE000_0000, 32'h1000_0000, 32'h0400_0000, 10'd100);
    wait_done("f1_timeout");
    chk("f1_npix", 32'(got_d.size()), 32'd8);
    chk("f1_starts", 32'(m_job), 32'd8);
    chk("f1_sof", 32'(m_sof), 32'd1);
    chk("f1_re31", lit_re, 32'hEC00_0000);
    chk("f1_im31", lit_im, 32'h0C00_0000);
    if (got_d.size() >= 4) begin
      chk("f1_d0", 32'(got_d[0]), 32'd5);
      chk("f1_d1", 32'(got_d[1]), 32'd9);
      chk("f1_d2", 32'(got_d[2]), 32'd0);
      chk("f1_d3", 32'(got_d[3]), 32'd10);
    end

    // back-pressure: ready low for 20 cycles after first pixel
    m_mode = 1;
    m_seed = 10'($urandom);
    rdy_mode = 2;
    start_frame($urandom, $urandom, $urandom, 10'($urandom));
    n = 0;
    while (!bus_if.out_valid && n < 200) begin
      @(negedge sysclk);
      n++;
    end
    if (!bus_if.out_valid) fail("f2_no_valid");
    repeat (20) begin
      @(negedge sysclk);
      chk("stall_valid", 32'(bus_if.out_valid), 32'd1);
    end
    chk("stall_jobs", 32'(m_job), 32'd2);
    rdy_mode = 0;
    wait_done("f2_timeout");
    chk("f2_npix", 32'(m_pix), 32'd8);

    // frame_start mid-frame must be ignored
    start_frame(32'h1234_5678, 32'h8765_4321, 32'h0010_0000, 10'd7);
    repeat (5) @(posedge sysclk);
    #1;
    re_origin = 32'hDEAD_BEEF;
    step = 32'h0F0F_0F0F;
    frame_start = 1'b1;
    @(posedge sysclk);
    #1;
    frame_start = 1'b0;
    wait_done("f3_timeout");
    chk("f3_npix", 32'(m_pix), 32'd8);
    chk("f3_sof", 32'(m_sof), 32'd1);

    // reset while waiting on pixel (2,0)
    start_frame($urandom, $urandom, $urandom, 10'($urandom));
    n = 0;
    while (!(bus_if.calc_start && bus_if.calc_x == 10'd2 &&
             bus_if.calc_y == 9'd0) && n < 200) begin
      @(negedge sysclk);
      n++;
    end
    if (n >= 200) fail("f4_no_pixel2");
    pulse_reset();
    @(negedge sysclk);
    chk_all_zero("abort");
    repeat (20) @(negedge sysclk);
    chk("abort_idle", 32'(frame_busy), 32'd0);

    // randomized frames
    c_rand_lat = 1;
    rdy_mode = 1;
    for (int f = 0; f < 8; f++) begin
      m_seed = 10'($urandom);
      start_frame($urandom, $urandom, $urandom, 10'($urandom));
      repeat ($urandom_range(0, 10)) @(posedge sysclk);
      #1;
      frame_start = 1'b1;
      @(posedge sysclk);
      #1;
      frame_start = 1'b0;
      wait_done("fr_timeout");
      chk("fr_npix", 32'(m_pix), 32'd8);
      chk("fr_starts", 32'(m_job), 32'd8);
    end

    repeat (5) @(negedge sysclk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/pixel_dispatcher.md
PIXEL_DISPATCHER -- requirements
Module: pixel_dispatcher

Interface
REQ-001 SHALL have parameter WORD_LENGTH, default 32, the signed fixed-point width of re/im values.
REQ-002 SHALL have parameter H_RES, default 640, the pixels per line.
REQ-003 SHALL have parameter V_RES, default 480, the lines per frame.
REQ-004 SHALL have port sysclk  in  1  single clock; one clock, reset is synchronous and active-low.
REQ-005 SHALL have port reset_n  in  1  synchronous active-low reset.
REQ-006 SHALL have ports re_origin, im_origin, step  in  WORD_LENGTH each  signed: pixel (0,0) coordinate and per-pixel increment.
REQ-007 SHALL have port max_iter_in  in  10  iteration limit for the frame.
REQ-008 SHALL have port frame_start  in  1  one-cycle request to render a frame.
REQ-009 SHALL have port frame_busy  out  1  high while a frame is in progress.
REQ-010 SHALL have ports calc_start out 1, calc_x out 10, calc_y out 9, calc_re_c out WORD_LENGTH, calc_im_c out WORD_LENGTH, calc_max_iter out 10  job request to the depth calculator.
REQ-011 SHALL have ports calc_done in 1 (level, stays high until next start), calc_depth in 10  job result.
REQ-012 SHALL have ports out_valid out 1, out_ready in 1, out_depth out 10, out_x out 10, out_y out 9, out_sof out 1, out_eol out 1  pixel result stream.

Function
REQ-013 SHALL latch re_origin, im_origin, step, max_iter_in on frame_start in IDLE and ignore all frame_start pulses while frame_busy=1.
REQ-014 SHALL implement states IDLE, LAUNCH, WAIT, FLUSH; IDLE->LAUNCH on frame_start; LAUNCH->WAIT always; WAIT->LAUNCH on capture of a non-final pixel; WAIT->FLUSH on capture of pixel (H_RES-1,V_RES-1); FLUSH->IDLE when result register empty.
REQ-015 SHALL assert calc_start for exactly one cycle, in LAUNCH only; calc_x/y/re_c/im_c SHALL be stable from LAUNCH until capture.
REQ-016 SHALL sample calc_done only in WAIT (the cycle after LAUNCH onward), so a stale done level from the previous job is never captured.
REQ-017 SHALL capture calc_depth/x/y into the one-entry result register in WAIT when calc_done=1 and (register empty or out_ready=1 that cycle); otherwise stay in WAIT, calculator holding its result.
REQ-018 SHALL generate coordinates incrementally without multipliers: x advance re_c+=step; x wrap to 0 re_c=re_origin, im_c-=step, y+=1; arithmetic modulo 2^WORD_LENGTH.
REQ-019 SHALL present out_valid while the result register is full; transfer occurs when out_valid and out_ready are both high; register SHALL refill in the same cycle as a transfer (no bubble).
REQ-020 SHALL set out_sof=1 for pixel (0,0) and out_eol=1 for x=H_RES-1, qualified by out_valid.
REQ-021 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-022 SHALL drive frame_busy=1 from the cycle after accepted frame_start until return to IDLE.
REQ-023 SHALL drive calc_max_iter from the latched value for the whole frame.

Reset
REQ-024 SHALL, on reset_n=0 at a sysclk edge, enter IDLE and clear frame_busy, calc_start, calc_x, calc_y, calc_re_c, calc_im_c, calc_max_iter, out_valid, out_depth, out_x, out_y, out_sof, out_eol to 0.
REQ-025 SHALL abandon any in-flight job on reset mid-frame; no pixel of the aborted frame SHALL appear after reset release.

Configuration
REQ-026 SHALL, with macro PIXEL_DISPATCHER_CYCLE_COUNT_EN defined, add output frame_cycles (32) that counts sysclk cycles while frame_busy=1, clears on accepted frame_start, holds after frame end, resets to 0.
REQ-027 SHALL, without PIXEL_DISPATCHER_CYCLE_COUNT_EN, omit the frame_cycles port and counter; all other behaviour identical.

Verification
REQ-028 H_RES=4,V_RES=2, re_origin=0xE0000000, im_origin=0x10000000, step=0x04000000, model done 3 cycles after start, out_ready=1 -> 8 pixels, out_x 0..3, out_y 0..1, pixel(3,1) calc_re_c=0xEC000000, calc_im_c=0x0C000000.
REQ-029 Model returns depths 5,9,0,10 with calc_done held high from previous job -> out_depth exactly 5,9,0,10, one calc_start per pixel, no duplicate capture.
REQ-030 out_ready=0 for 20 cycles after first pixel -> out_valid held, out_* stable, second result captured only when out_ready rises, no pixel lost.
REQ-031 frame_start pulsed at cycle 5 mid-frame -> ignored, frame_busy continuous, pixel count still H_RES*V_RES, out_sof once.
REQ-032 reset_n low for 1 cycle while in WAIT at pixel (2,0) -> all outputs 0 next cycle, IDLE, no output until new frame_start.
REQ-033 With PIXEL_DISPATCHER_CYCLE_COUNT_EN, fixed 3-cycle model, 4x2 frame, out_ready=1 -> frame_cycles equals measured frame_busy high-cycle count.
